// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared constants, state and error enums for the I2C command sequencer
package i2c_seq_pkg;
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;
  localparam logic [7:0] CTR_EN         = 8'h80;
  localparam logic [7:0] CR_STA_WR      = 8'h90;
  localparam logic [7:0] CR_WR          = 8'h10;
  localparam logic [7:0] CR_WR_STO      = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STO         = 8'h40;
  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE, WR_TXR, WR_CR,
    POLL, CHECK, RD_RX, STOP_CR, STOP_POLL, DONE
  } state_t;
  typedef enum logic [1:0] {ERR_OK, ERR_NACK, ERR_AL, ERR_TIMEOUT} err_t;
  function automatic logic [7:0] cr_cmd(input logic [1:0] idx, input logic rd);
    return idx == 2'd0 ? CR_STA_WR :
           idx == 2'd1 ? CR_WR :
           idx == 2'd3 ? CR_RD_NACK_STO :
           rd ? CR_STA_WR : CR_WR_STO;
  endfunction
endpackage

// File: rtl/i2c_seq_wbm.sv
// i2c_seq_wbm: single-access WISHBONE master engine, holds the access until ack
module i2c_seq_wbm (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_we,
  input  logic [2:0] i_adr,
  input  logic [7:0] i_dat,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);
  logic       r_cyc;
  logic       r_we;
  logic [2:0] r_adr;
  logic [7:0] r_dat;
  logic [7:0] r_rdata;
  assign o_busy    = r_cyc;
  assign o_done    = r_cyc && wbm_ack_i;
  assign o_rdata   = r_rdata;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_we_o  = r_we;
  assign wbm_stb_o = r_cyc;
  assign wbm_cyc_o = r_cyc;
  // launch an access on start, hold it stable, release the bus on the edge after ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 3'd0;
      r_dat   <= 8'h00;
      r_rdata <= 8'h00;
    end else if (r_cyc && wbm_ack_i) begin
      r_cyc   <= 1'b0;
      r_rdata <= r_we ? r_rdata : wbm_dat_i;
    end else if (i_start && !r_cyc) begin
      r_cyc <= 1'b1;
      r_we  <= i_we;
      r_adr <= i_adr;
      r_dat <= i_dat;
    end
  end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: register read/write sequencer over an I2C master core (I2C_SEQ_TIMEOUT_EN adds SR poll timeout)
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE      = 16'h0063,
  parameter int unsigned TIMEOUT_POLLS = 1023
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [1:0] resp_err,
  output logic [7:0] resp_rdata,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);
  localparam int PW = $clog2(TIMEOUT_POLLS + 2);
  localparam logic [PW-1:0] PMAX = PW'(TIMEOUT_POLLS);
  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_idx;
  logic          r_rd;
  logic [6:0]    r_dev;
  logic [7:0]    r_reg;
  logic [7:0]    r_wdata;
  err_t          r_err;
  logic [PW-1:0] r_polls;
  logic          w_acc;
  logic          w_we;
  logic [2:0]    w_adr;
  logic [7:0]    w_dat;
  logic          w_start;
  logic          w_busy;
  logic          w_done;
  logic [7:0]    w_sr;
  logic [7:0]    w_txr;
  logic [7:0]    w_cr;
  logic          w_last;
  logic          w_rdbyte;
  logic          w_nack;
  logic          w_tmo;
  assign req_ready = r_state == IDLE;
  assign w_start   = w_acc && !w_busy;
  assign w_last    = r_rd ? r_idx == 2'd3 : r_idx == 2'd2;
  assign w_rdbyte  = r_rd && r_idx == 2'd3;
  assign w_nack    = w_sr[SR_RXACK] && !w_rdbyte;
  assign w_txr     = r_idx == 2'd0 ? {r_dev, 1'b0} :
                     r_idx == 2'd1 ? r_reg :
                     r_rd ? {r_dev, 1'b1} : r_wdata;
  assign w_cr      = cr_cmd(r_idx, r_rd);
`ifdef I2C_SEQ_TIMEOUT_EN
  assign w_tmo = r_polls >= PMAX;
`else
  assign w_tmo = 1'b0;
`endif
  i2c_seq_wbm u_wbm (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_start   (w_start),
    .i_we      (w_we),
    .i_adr     (w_adr),
    .i_dat     (w_dat),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_rdata   (w_sr),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );
  // state register
  always_ff @(posedge wb_clk_i) begin
    r_state <= wb_rst_i ? INIT_PRL : w_next;
  end
  // next state and the bus access each state requests
  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    w_we   = 1'b1;
    w_adr  = ADR_PRERLO;
    w_dat  = 8'h00;
    case (r_state)
      INIT_PRL: begin
        w_acc  = 1'b1;
        w_dat  = PRESCALE[7:0];
        w_next = w_done ? INIT_PRH : r_state;
      end
      INIT_PRH: begin
        w_acc  = 1'b1;
        w_adr  = ADR_PRERHI;
        w_dat  = PRESCALE[15:8];
        w_next = w_done ? INIT_CTR : r_state;
      end
      INIT_CTR: begin
        w_acc  = 1'b1;
        w_adr  = ADR_CTR;
        w_dat  = CTR_EN;
        w_next = w_done ? IDLE : r_state;
      end
      IDLE: w_next = req_valid ? WR_TXR : r_state;
      WR_TXR: begin
        w_acc  = 1'b1;
        w_adr  = ADR_TXR;
        w_dat  = w_txr;
        w_next = w_done ? WR_CR : r_state;
      end
      WR_CR: begin
        w_acc  = 1'b1;
        w_adr  = ADR_CR;
        w_dat  = w_cr;
        w_next = w_done ? POLL : r_state;
      end
      POLL: begin
        w_acc  = 1'b1;
        w_we   = 1'b0;
        w_adr  = ADR_SR;
        w_next = w_done ? CHECK : r_state;
      end
      CHECK: w_next = w_sr[SR_TIP] ? (w_tmo ? DONE : POLL) :
                      w_sr[SR_AL] ? DONE :
                      w_nack ? STOP_CR :
                      !w_last ? ((r_rd && r_idx == 2'd2) ? WR_CR : WR_TXR) :
                      r_rd ? RD_RX : DONE;
      RD_RX: begin
        w_acc  = 1'b1;
        w_we   = 1'b0;
        w_adr  = ADR_RXR;
        w_next = w_done ? DONE : r_state;
      end
      STOP_CR: begin
        w_acc  = 1'b1;
        w_adr  = ADR_CR;
        w_dat  = CR_STO;
        w_next = w_done ? STOP_POLL : r_state;
      end
      STOP_POLL: begin
        w_acc  = 1'b1;
        w_we   = 1'b0;
        w_adr  = ADR_SR;
        w_next = (w_done && !wbm_dat_i[SR_TIP]) ? DONE : r_state;
      end
      DONE: w_next = IDLE;
      default: w_next = INIT_PRL;
    endcase
  end
  // request latch, byte index, poll counter, error capture and response outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idx      <= 2'd0;
      r_rd       <= 1'b0;
      r_dev      <= 7'd0;
      r_reg      <= 8'h00;
      r_wdata    <= 8'h00;
      r_err      <= ERR_OK;
      r_polls    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 2'd0;
      resp_rdata <= 8'h00;
    end else begin
      resp_valid <= r_state == DONE;
      if (r_state == IDLE && req_valid) begin
        r_idx   <= 2'd0;
        r_rd    <= req_rd;
        r_dev   <= req_dev;
        r_reg   <= req_reg;
        r_wdata <= req_wdata;
        r_err   <= ERR_OK;
      end
      if (r_state == WR_CR)
        r_polls <= '0;
      else if (r_state == POLL && w_done)
        r_polls <= r_polls == PMAX ? r_polls : r_polls + 1'b1;
      if (r_state == CHECK) begin
        r_err <= w_sr[SR_TIP] ? (w_tmo ? ERR_TIMEOUT : r_err) :
                 w_sr[SR_AL] ? ERR_AL :
                 w_nack ? ERR_NACK : r_err;
        r_idx <= (!w_sr[SR_TIP] && !w_sr[SR_AL] && !w_nack && !w_last) ? r_idx + 2'd1 : r_idx;
      end
      if (r_state == DONE) begin
        resp_err   <= r_err;
        resp_rdata <= (r_rd && r_err == ERR_OK) ? w_sr : 8'h00;
      end
    end
  end
endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'h0063, the value written to PRERlo/PRERhi at init.
REQ-002 SHALL have parameter TIMEOUT_POLLS, default 1023, the maximum number of SR polls per byte (used only with REQ-030).
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  transaction request.
REQ-006 SHALL have port req_ready  out  1  sequencer idle and accepting.
REQ-007 SHALL have port req_rd  in  1  1 = register read, 0 = register write.
REQ-008 SHALL have port req_dev  in  7  I2C device address.
REQ-009 SHALL have port req_reg  in  8  device register address.
REQ-010 SHALL have port req_wdata  in  8  write data.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_err  out  2  error code: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout.
REQ-013 SHALL have port resp_rdata  out  8  read data, valid with resp_valid.
REQ-014 SHALL have ports wbm_adr_o (out 3), wbm_dat_o (out 8), wbm_dat_i (in 8), wbm_we_o (out 1), wbm_stb_o (out 1), wbm_cyc_o (out 1) and wbm_ack_i (in 1), forming the WISHBONE master to the I2C core.

Function
REQ-015 SHALL perform every WISHBONE access as a single cycle: cyc/stb/we/adr/dat stay asserted and stable until wbm_ack_i, and cyc/stb drop in the cycle after ack.
REQ-016 SHALL sample wbm_dat_i on the ack cycle of a read access.
REQ-017 SHALL execute INIT after reset: write PRERlo (adr 0) = PRESCALE[7:0], PRERhi (adr 1) = PRESCALE[15:8], then CTR (adr 2) = 8'h80; then enter IDLE.
REQ-018 SHALL drive req_ready high only in IDLE; a request is accepted when req_valid && req_ready, and all req_* fields are latched at that edge.
REQ-019 SHALL send each byte as: write TXR (adr 3), write CR (adr 4), then read SR (adr 4) repeatedly until SR[1] (TIP) = 0.
REQ-020 SHALL use this byte list for a write: {dev,0} with CR 8'h90; reg with CR 8'h10; wdata with CR 8'h50.
REQ-021 SHALL use this byte list for a read: {dev,0} with CR 8'h90; reg with CR 8'h10; {dev,1} with CR 8'h90; then CR 8'h68 with no TXR write, then a RXR read (adr 3) into resp_rdata.
REQ-022 SHALL, after each poll that completes (TIP = 0), check in priority order: SR[5] (AL) = 1 gives err 2; SR[7] (RxACK) = 1 on a write-phase byte gives err 1.
REQ-023 SHALL, on err 1, write CR 8'h40 (STOP), poll until TIP = 0, then complete.
REQ-024 SHALL, on err 2, skip the STOP write and complete immediately.
REQ-025 SHALL ignore RxACK on the final read byte (the master sends the NACK).
REQ-026 SHALL pulse resp_valid for exactly one cycle per accepted request and return to IDLE in the same cycle; the next request may be accepted in the following cycle.
REQ-027 SHALL hold resp_rdata at 8'h00 for writes and errored reads; resp_err and resp_rdata hold their values until the next resp_valid.
REQ-028 SHALL use states INIT_PRL, INIT_PRH, INIT_CTR, IDLE, WR_TXR, WR_CR, POLL, CHECK, RD_RX, STOP_CR, STOP_POLL, DONE, with a 2-bit byte index selecting TXR/CR values.

Reset
REQ-029 SHALL, when wb_rst_i is asserted (including mid-access or mid-transaction), in the next cycle: set cyc/stb/we = 0, adr = 0, dat_o = 0, req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, state = INIT_PRL; any in-flight request is dropped with no response.

Configuration
REQ-030 SHALL, with I2C_SEQ_TIMEOUT_EN defined, count SR polls per byte and complete with err 3 after TIMEOUT_POLLS polls with TIP still 1, with no STOP write; without the macro SHALL poll indefinitely and never produce err 3.

Structure
REQ-031 SHALL place register address constants, CR command constants (8'h90, 8'h10, 8'h50, 8'h68, 8'h40), SR bit indices, the state enum and the error-code enum in package i2c_seq_pkg.
REQ-032 SHALL implement the single-access engine of REQ-015/REQ-016 as sub-module i2c_seq_wbm, and the sequencing FSM in the top level.

Verification
REQ-033 Bench SHALL check: reset release -> WB writes (0,8'h63), (1,8'h00), (2,8'h80) in order, then req_ready = 1.
REQ-034 Bench SHALL check: write dev=7'h50 reg=8'h12 data=8'hA5, core model always ACKs -> TXR/CR pairs (8'hA0,8'h90), (8'h12,8'h10), (8'hA5,8'h50); resp_err = 0; one resp_valid pulse.
REQ-035 Bench SHALL check: read dev=7'h50 reg=8'h34, model RXR = 8'h3C -> CR sequence 8'h90, 8'h10, 8'h90 (TXR 8'hA1), 8'h68; resp_rdata = 8'h3C; resp_err = 0.
REQ-036 Bench SHALL check: model returns RxACK = 1 on the address byte -> CR 8'h40 is written; resp_err = 1; no further TXR writes.
REQ-037 Bench SHALL check: model returns AL = 1 on the second byte -> resp_err = 2 with no STOP write; with I2C_SEQ_TIMEOUT_EN and TIMEOUT_POLLS = 4, TIP stuck at 1 -> exactly 4 SR reads, then resp_err = 3.
REQ-038 Bench SHALL check: wb_rst_i asserted during a POLL access -> cyc/stb low in the next cycle, no resp_valid, and INIT repeats.
